// File: rtl/dispatcher_pkg.sv
// Shared lane-field layout and popcount helper for the dispatcher and
// lane collector; lane i = {valid, ctrl..., data} packed LSB-first.
package dispatcher_pkg;

  localparam int MAX_LANES = 64;

  function automatic int lane_w(input int lbw, input int cb);
    return (2 ** lbw) + cb;
  endfunction

  function automatic int data_lo(input int i, input int lbw, input int cb);
    return i * lane_w(lbw, cb);
  endfunction

  function automatic int valid_pos(input int i, input int lbw, input int cb);
    return (i + 1) * lane_w(lbw, cb) - 1;
  endfunction

  function automatic int popcount(input logic [MAX_LANES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + (v[i] ? 1 : 0);
    end
    return n;
  endfunction

endpackage

// File: rtl/lane_compactor.sv
// Prefix sum over lane valids: per-lane write offset, accept mask
// limited by free slots, accepted total and drop indication.
module lane_compactor
  import dispatcher_pkg::*;
#(
  parameter int LANES = 8,
  parameter int FW    = 5,
  parameter int PW    = 4
) (
  input  logic [LANES-1:0]         valid_i,
  input  logic [FW-1:0]            free_i,
  output logic [LANES-1:0][PW-1:0] offset_o,
  output logic [LANES-1:0]         accept_o,
  output logic [FW-1:0]            acc_cnt_o,
  output logic                     drop_o
);

  logic [FW-1:0]          run;
  logic [FW-1:0]          total;
  logic [MAX_LANES-1:0]   vx;

  always_comb begin
    run      = '0;
    offset_o = '0;
    accept_o = '0;
    for (int i = 0; i < LANES; i++) begin
      offset_o[i] = run[PW-1:0];
      accept_o[i] = valid_i[i] && (run < free_i);
      run         = run + {{(FW-1){1'b0}}, valid_i[i]};
    end
  end

  always_comb begin
    vx             = '0;
    vx[LANES-1:0]  = valid_i;
    total          = FW'(popcount(vx));
    drop_o         = total > free_i;
    acc_cnt_o      = drop_o ? free_i : total;
  end

endmodule

// File: rtl/lane_collector.sv
// Multi-lane compacting FIFO with first-word fall-through output.
// Define LANE_COLLECTOR_OVF_EN for a sticky dropped-word flag.
module lane_collector
  import dispatcher_pkg::*;
#(
  parameter int log_bit_width = 5,
  parameter int ctrl_bit      = 1,
  parameter int log_in_ports  = 3,
  parameter int log_fifo_size = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [(2**log_in_ports)*((2**log_bit_width)+ctrl_bit)-1:0]
               data_in,
  output logic [(2**log_in_ports)-1:0]  stall_word,
  output logic [(2**log_bit_width)-1:0] dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [log_fifo_size:0]        count,
  output logic                          overflow
);

  localparam int DW    = 2 ** log_bit_width;
  localparam int LANES = 2 ** log_in_ports;
  localparam int DEPTH = 2 ** log_fifo_size;
  localparam int PW    = log_fifo_size;
  localparam int CW    = log_fifo_size + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [LANES-1:0][DW-1:0] lane_dat;
  logic [LANES-1:0]         lane_vld;
  logic [LANES-1:0][PW-1:0] offset;
  logic [LANES-1:0]         accept;
  logic [CW-1:0]            acc_cnt;
  logic [CW-1:0]            free;
  logic                     drop;
  logic                     pop;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int LO = data_lo(g, log_bit_width, ctrl_bit);
    localparam int VP = valid_pos(g, log_bit_width, ctrl_bit);
    assign lane_dat[g] = data_in[LO +: DW];
    assign lane_vld[g] = data_in[VP];
  end

  assign pop  = dout_ready && (cnt_q != '0);
  assign free = CW'(DEPTH) - cnt_q + {{(CW-1){1'b0}}, pop};

  lane_compactor #(
    .LANES (LANES),
    .FW    (CW),
    .PW    (PW)
  ) u_compactor (
    .valid_i   (lane_vld),
    .free_i    (free),
    .offset_o  (offset),
    .accept_o  (accept),
    .acc_cnt_o (acc_cnt),
    .drop_o    (drop)
  );

  always_comb begin
    cnt_d = cnt_q + acc_cnt - {{(CW-1){1'b0}}, pop};
    wr_d  = wr_q + acc_cnt[PW-1:0];
    rd_d  = rd_q + {{(PW-1){1'b0}}, pop};
  end

`ifdef LANE_COLLECTOR_OVF_EN
  assign ovf_d = ovf_q | drop;
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign ovf_d       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage is never reset; pointers alone define what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (accept[i]) begin
        mem_q[wr_q + offset[i]] <= lane_dat[i];
      end
    end
  end

  // One full burst of headroom covers the dispatcher's output register.
  always_comb begin
    stall_word = '0;
    for (int i = 0; i < LANES; i++) begin
      stall_word[i] = (DEPTH - int'(cnt_q)) < (i + 1 + LANES);
    end
  end

  assign dout       = mem_q[rd_q];
  assign dout_valid = cnt_q != '0;
  assign count      = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/lane_collector.md
LANE_COLLECTOR -- requirements
Module: lane_collector

Interface
REQ-001 SHALL have parameter log_bit_width, default 5; data word width is 2**log_bit_width.
REQ-002 SHALL have parameter ctrl_bit, default 1; valid-flag width per lane.
REQ-003 SHALL have parameter log_in_ports, default 3; lane count LANES = 2**log_in_ports.
REQ-004 SHALL have parameter log_fifo_size, default 4; DEPTH = 2**log_fifo_size, legal only if log_fifo_size >= log_in_ports+1.
REQ-005 SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port data_in, input, LANES*(2**log_bit_width+ctrl_bit); lane i data at [i*LW +: 2**log_bit_width], valid at bit (i+1)*LW-1, where LW = 2**log_bit_width+ctrl_bit.
REQ-008 SHALL have port stall_word, output, LANES, per-lane back-pressure to the dispatcher; 1 = do not fill lane i.
REQ-009 SHALL have port dout, output, 2**log_bit_width, head-of-FIFO word.
REQ-010 SHALL have port dout_valid, output, 1, head word present.
REQ-011 SHALL have port dout_ready, input, 1, consumer accepts dout.
REQ-012 SHALL have port count, output, log_fifo_size+1, current occupancy.
REQ-013 SHALL have port overflow, output, 1, sticky dropped-word flag.

Function
REQ-014 SHALL each cycle write every lane with valid=1 into the FIFO in ascending lane order at consecutive locations, skipping invalid lanes (compaction).
REQ-015 SHALL pop one word on a rising edge when dout_valid=1 and dout_ready=1.
REQ-016 SHALL present dout = mem[rd_ptr] combinationally (first-word fall-through); dout_valid = (count != 0).
REQ-017 SHALL make a written word visible on dout one cycle after its data_in cycle when the FIFO was empty.
REQ-018 SHALL allow simultaneous push and pop in one cycle; count_next = count + accepted - pop.
REQ-019 SHALL wrap rd_ptr and wr_ptr modulo DEPTH.
REQ-020 SHALL drive stall_word[i] = 1 when (DEPTH - count) < (i+1) + LANES, derived from registered count only, reserving one in-flight burst for the dispatcher's registered output.
REQ-021 SHALL accept a valid word only while a free slot remains after earlier-indexed accepted words and this cycle's pop; otherwise SHALL drop it.
REQ-022 SHALL ignore data bits of lanes with valid=0.
REQ-023 SHALL not pop when count = 0, regardless of dout_ready.

Reset
REQ-024 SHALL on rst_n=0 immediately clear rd_ptr, wr_ptr, count and overflow, giving dout_valid=0 and stall_word=0.
REQ-025 SHALL discard all stored words on reset mid-operation; memory contents SHALL not be reset.

Configuration
REQ-026 SHALL, with LANE_COLLECTOR_OVF_EN defined, set overflow on any dropped word (REQ-021) and hold it until reset.
REQ-027 SHALL, without LANE_COLLECTOR_OVF_EN, tie overflow to 0 and drop excess words silently.

Structure
REQ-028 SHALL take lane field offsets (LW, data and valid positions) and a popcount function from shared package dispatcher_pkg, also used by the dispatcher side.
REQ-029 SHALL instantiate one sub-module lane_compactor: combinational prefix sum over lane valids giving each lane's write offset and the accepted total.

Verification (defaults: 32-bit words, LANES=8, DEPTH=16)
REQ-030 SHALL check reset: rst_n low then high -> stall_word=8'h00, dout_valid=0, count=0, overflow=0.
REQ-031 SHALL check compaction: lanes 0,2,5 valid with 0xA0,0xA2,0xA5, dout_ready=0 -> count=3; then dout_ready=1 -> dout 0xA0, 0xA2, 0xA5 on consecutive cycles, then dout_valid=0.
REQ-032 SHALL check stall thresholds: count=0 -> 8'h00; count=1 -> 8'h80; count=4 -> 8'hF0; count>=8 -> 8'hFF.
REQ-033 SHALL check wrap and concurrency: wr_ptr=14, push 4 words while popping 1 per cycle -> data in order across the 15->0 wrap, count tracks push minus pop exactly.
REQ-034 SHALL check overflow: count=12, dout_ready=0, all 8 lanes valid -> first 4 lanes stored, count=16, overflow=1 with LANE_COLLECTOR_OVF_EN, 0 without.
REQ-035 SHALL check reset mid-operation: count=5, rst_n asserted asynchronously -> count=0 and dout_valid=0 before the next clk edge.
